// File: rtl/odu_chk_pkg.sv
// -----------------------------------------------------------------------------
// odu_chk_pkg
// Shared constants, types and helpers for the ODU data checker. The checker
// sits downstream of odu_gen_data_top and checks a per-channel incrementing
// sequence carried in the low bits of each generated word.
// -----------------------------------------------------------------------------
package odu_chk_pkg;

  // Datapath geometry
  localparam int NUM_CH  = 80;   // valid chid 0..NUM_CH-1
  localparam int DATA_W  = 387;  // generator word width
  localparam int SEQ_W   = 32;   // checked field data_in[SEQ_W-1:0]
  localparam int ERR_W   = 16;   // per-channel saturating error counter
  localparam int CHID_W  = 7;    // channel id width on the stream

  // Global counter widths
  localparam int TOTAL_W = 32;
  localparam int BAD_W   = 16;
  localparam int WORDS_W = 32;

  // Cfg bus geometry (same style as the generator control block)
  localparam int CFG_AW  = 4;
  localparam int CFG_DW  = 16;

  // Register map
  localparam logic [CFG_AW-1:0] ADDR_CTRL     = 4'h0;
  localparam logic [CFG_AW-1:0] ADDR_SEL      = 4'h1;
  localparam logic [CFG_AW-1:0] ADDR_ERR_CNT  = 4'h2;
  localparam logic [CFG_AW-1:0] ADDR_LOCK     = 4'h3;
  localparam logic [CFG_AW-1:0] ADDR_TOTAL_LO = 4'h4;
  localparam logic [CFG_AW-1:0] ADDR_TOTAL_HI = 4'h5;
  localparam logic [CFG_AW-1:0] ADDR_BADCHID  = 4'h6;
  localparam logic [CFG_AW-1:0] ADDR_WORDS_LO = 4'h7;
  localparam logic [CFG_AW-1:0] ADDR_WORDS_HI = 4'h8;

  // CTRL register bit positions
  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_CLEAR_BIT  = 1;

  // First pipeline stage: the qualified word reduced to what the check needs
  typedef struct packed {
    logic              valid;
    logic [CHID_W-1:0] chid;
    logic [SEQ_W-1:0]  seq;
  } s1_t;

  // Saturating increments: counters stick at all-ones instead of wrapping
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/odu_chk_cfg_regs.sv
// -----------------------------------------------------------------------------
// odu_chk_cfg_regs
// Cfg bus slave for the ODU data checker: decodes active-low chip select /
// write / output enables, holds CTRL.enable and SEL, produces the one-cycle
// clear strobe, and returns status through a registered read mux.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   cfg_n_cs/_we/_oe      active-low chip select, write enable, output enable
//   cfg_addr, cfg_din     register address and write data
//   cfg_dout              registered read data (0 when not being read)
//   err_cnt_sel, lock_sel error count / lock bit of the SEL channel
//   total, badchid, words global status counters
//   enable                CTRL.enable
//   sel                   channel select for ERR_CNT / LOCK
//   clear                 one-cycle strobe, same edge as the CTRL write
// -----------------------------------------------------------------------------
module odu_chk_cfg_regs
  import odu_chk_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_n_cs,
  input  logic              cfg_n_we,
  input  logic              cfg_n_oe,
  input  logic [CFG_AW-1:0] cfg_addr,
  input  logic [CFG_DW-1:0] cfg_din,
  output logic [CFG_DW-1:0] cfg_dout,
  input  logic [ERR_W-1:0]  err_cnt_sel,
  input  logic              lock_sel,
  input  logic [TOTAL_W-1:0] total,
  input  logic [BAD_W-1:0]  badchid,
  input  logic [WORDS_W-1:0] words,
  output logic              enable,
  output logic [CHID_W-1:0] sel,
  output logic              clear
);

  logic              wr_en;
  logic              rd_en;
  logic [CFG_DW-1:0] rd_data;
  logic              unused_din_bits;

  assign wr_en = !cfg_n_cs && !cfg_n_we;
  assign rd_en = !cfg_n_cs && !cfg_n_oe;

  // Clear is taken straight from the bus so it acts on the same edge as the
  // write; it is never stored, which is what makes it self-clearing.
  assign clear = wr_en && (cfg_addr == ADDR_CTRL) && cfg_din[CTRL_CLEAR_BIT];

  // Only the low channel-select bits of the write data are ever stored.
  assign unused_din_bits = ^cfg_din[CFG_DW-1:CHID_W];

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable <= 1'b0;
      sel    <= '0;
    end else if (wr_en) begin
      case (cfg_addr)
        ADDR_CTRL: enable <= cfg_din[CTRL_ENABLE_BIT];
        ADDR_SEL:  sel    <= cfg_din[CHID_W-1:0];
        default:   ;
      endcase
    end
  end

  // NOTE: rd_data gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_data = '0;
    case (cfg_addr)
      ADDR_CTRL:     rd_data[CTRL_ENABLE_BIT] = enable;
      ADDR_SEL:      rd_data[CHID_W-1:0]      = sel;
      ADDR_ERR_CNT:  rd_data                  = err_cnt_sel;
      ADDR_LOCK:     rd_data[0]               = lock_sel;
      ADDR_TOTAL_LO: rd_data                  = total[15:0];
      ADDR_TOTAL_HI: rd_data                  = total[31:16];
      ADDR_BADCHID:  rd_data                  = badchid;
      ADDR_WORDS_LO: rd_data                  = words[15:0];
      ADDR_WORDS_HI: rd_data                  = words[31:16];
      default:       rd_data                  = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_dout <= '0;
    end else begin
      cfg_dout <= rd_en ? rd_data : '0;
    end
  end

endmodule

// File: rtl/odu_data_checker.sv
// -----------------------------------------------------------------------------
// odu_data_checker
// Checks the per-channel incrementing sequence in data_in[SEQ_W-1:0] for
// NUM_CH channels. Two stages: S1 registers the qualified word, S2 compares
// against the channel's expected value and updates the tables. A word in
// cycle N produces err_pulse/err_chid in cycle N+2. Full rate, no stall.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   data_valid        qualifies chid_in/data_in this cycle
//   chid_in           channel id of the word
//   data_in           generator word; only the low SEQ_W bits are checked
//   cfg_*             16-bit cfg bus (see odu_chk_cfg_regs)
//   err_pulse         one-cycle pulse per sequence error
//   err_chid          channel of the error, valid with err_pulse
// -----------------------------------------------------------------------------
module odu_data_checker
  import odu_chk_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              data_valid,
  input  logic [CHID_W-1:0] chid_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              cfg_n_cs,
  input  logic              cfg_n_we,
  input  logic              cfg_n_oe,
  input  logic [CFG_AW-1:0] cfg_addr,
  input  logic [CFG_DW-1:0] cfg_din,
  output logic [CFG_DW-1:0] cfg_dout,
  output logic              err_pulse,
  output logic [CHID_W-1:0] err_chid
);

  // Control from the cfg block
  logic              enable;
  logic              clear;
  logic [CHID_W-1:0] sel;

  // Pipeline stage 1
  s1_t               s1_q;

  // Per-channel tables
  logic [SEQ_W-1:0]  exp_tbl [NUM_CH];
  logic [ERR_W-1:0]  err_tbl [NUM_CH];
  logic [NUM_CH-1:0] lock_tbl;

  // Global counters
  logic [TOTAL_W-1:0] total_q;
  logic [BAD_W-1:0]   badchid_q;
  logic [WORDS_W-1:0] words_q;

  // Stage 2 decode
  logic              chid_ok;
  logic              accept;
  logic              bad_word;
  logic              mismatch;
  logic [SEQ_W-1:0]  cur_exp;
  logic              cur_lock;
  logic [SEQ_W-1:0]  next_exp;

  // Status of the selected channel
  logic              sel_ok;
  logic [ERR_W-1:0]  err_cnt_sel;
  logic              lock_sel;

  // Bits above the sequence field are payload this block does not inspect.
  logic              unused_payload;
  assign unused_payload = ^data_in[DATA_W-1:SEQ_W];

  // ---------------------------------------------------------------------------
  // Stage 1: qualify and register. Words arriving while disabled enter as
  // bubbles, so they cannot touch any state downstream.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
    end else begin
      s1_q.valid <= data_valid && enable;
      s1_q.chid  <= chid_in;
      s1_q.seq   <= data_in[SEQ_W-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: compare. The tables are flops read directly here, so a write by
  // the previous S2 word is already visible when the same channel follows
  // back-to-back; that direct read is the forwarding path.
  // ---------------------------------------------------------------------------
  always_comb begin
    chid_ok  = s1_q.chid < CHID_W'(NUM_CH);
    cur_exp  = '0;
    cur_lock = 1'b0;
    if (chid_ok) begin
      cur_exp  = exp_tbl[s1_q.chid];
      cur_lock = lock_tbl[s1_q.chid];
    end
    accept   = s1_q.valid && chid_ok;
    bad_word = s1_q.valid && !chid_ok;
    mismatch = accept && cur_lock && (s1_q.seq != cur_exp);
    // Expected always resyncs to the received value + 1; wraps mod 2^SEQ_W.
    next_exp = s1_q.seq + SEQ_W'(1);
  end

  // NOTE: the tables are reset and cleared as a whole in one cycle, so they
  // must be flops, not RAM; a RAM macro cannot be zeroed by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_tbl <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        exp_tbl[i] <= '0;
        err_tbl[i] <= '0;
      end
    end else if (clear) begin
      // Clear wins over any update from a coincident S2 word.
      lock_tbl <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        exp_tbl[i] <= '0;
        err_tbl[i] <= '0;
      end
    end else if (accept) begin
      exp_tbl[s1_q.chid]  <= next_exp;
      lock_tbl[s1_q.chid] <= 1'b1;
      if (mismatch) begin
        err_tbl[s1_q.chid] <= sat_inc16(err_tbl[s1_q.chid]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total_q   <= '0;
      badchid_q <= '0;
      words_q   <= '0;
    end else if (clear) begin
      total_q   <= '0;
      badchid_q <= '0;
      words_q   <= '0;
    end else begin
      if (mismatch) total_q   <= sat_inc32(total_q);
      if (bad_word) badchid_q <= sat_inc16(badchid_q);
      if (accept)   words_q   <= sat_inc32(words_q);
    end
  end

  // The error report ignores clear: a mismatch seen in S2 is always flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_pulse <= 1'b0;
      err_chid  <= '0;
    end else begin
      err_pulse <= mismatch;
      err_chid  <= mismatch ? s1_q.chid : '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Selected-channel status; out-of-range selects read as zero.
  // ---------------------------------------------------------------------------
  always_comb begin
    sel_ok      = sel < CHID_W'(NUM_CH);
    err_cnt_sel = '0;
    lock_sel    = 1'b0;
    if (sel_ok) begin
      err_cnt_sel = err_tbl[sel];
      lock_sel    = lock_tbl[sel];
    end
  end

  odu_chk_cfg_regs u_cfg_regs (
    .clk         (clk),
    .rst         (rst),
    .cfg_n_cs    (cfg_n_cs),
    .cfg_n_we    (cfg_n_we),
    .cfg_n_oe    (cfg_n_oe),
    .cfg_addr    (cfg_addr),
    .cfg_din     (cfg_din),
    .cfg_dout    (cfg_dout),
    .err_cnt_sel (err_cnt_sel),
    .lock_sel    (lock_sel),
    .total       (total_q),
    .badchid     (badchid_q),
    .words       (words_q),
    .enable      (enable),
    .sel         (sel),
    .clear       (clear)
  );

endmodule

// File: tb/tb_odu_data_checker.sv
// -----------------------------------------------------------------------------
// tb_odu_data_checker
// Directed bench for odu_data_checker. Each task drives one scenario and
// compares against hand-computed values inline.
// -----------------------------------------------------------------------------
module tb_odu_data_checker;
  import odu_chk_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              data_valid = 1'b0;
  logic [CHID_W-1:0] chid_in = '0;
  logic [DATA_W-1:0] data_in = '0;
  logic              cfg_n_cs = 1'b1;
  logic              cfg_n_we = 1'b1;
  logic              cfg_n_oe = 1'b1;
  logic [CFG_AW-1:0] cfg_addr = '0;
  logic [CFG_DW-1:0] cfg_din = '0;
  logic [CFG_DW-1:0] cfg_dout;
  logic              err_pulse;
  logic [CHID_W-1:0] err_chid;

  int total = 0;
  int bad = 0;
  int pulse_cnt = 0;

  odu_data_checker dut (
    .clk        (clk),
    .rst        (rst),
    .data_valid (data_valid),
    .chid_in    (chid_in),
    .data_in    (data_in),
    .cfg_n_cs   (cfg_n_cs),
    .cfg_n_we   (cfg_n_we),
    .cfg_n_oe   (cfg_n_oe),
    .cfg_addr   (cfg_addr),
    .cfg_din    (cfg_din),
    .cfg_dout   (cfg_dout),
    .err_pulse  (err_pulse),
    .err_chid   (err_chid)
  );

  always #5 clk = ~clk;

  // Count every error pulse, sampled away from the active edge.
  always @(negedge clk) begin
    if (err_pulse === 1'b1) pulse_cnt++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Payload bits above the sequence field are all ones: they must be ignored.
  task automatic send(input logic [CHID_W-1:0] ch, input logic [SEQ_W-1:0] seq);
    data_valid = 1'b1;
    chid_in    = ch;
    data_in    = {{(DATA_W-SEQ_W){1'b1}}, seq};
    tick();
    data_valid = 1'b0;
  endtask

  task automatic cfg_write(input logic [CFG_AW-1:0] a, input logic [CFG_DW-1:0] d);
    cfg_n_cs = 1'b0;
    cfg_n_we = 1'b0;
    cfg_addr = a;
    cfg_din  = d;
    tick();
    cfg_n_cs = 1'b1;
    cfg_n_we = 1'b1;
  endtask

  task automatic cfg_read(input logic [CFG_AW-1:0] a, output logic [CFG_DW-1:0] d);
    cfg_n_cs = 1'b0;
    cfg_n_oe = 1'b0;
    cfg_addr = a;
    tick();
    d = cfg_dout;
    cfg_n_cs = 1'b1;
    cfg_n_oe = 1'b1;
  endtask

  task automatic test_reset();
    logic [CFG_DW-1:0] rd;
    rst = 1'b1;
    cfg_n_cs = 1'b0;
    cfg_n_oe = 1'b0;
    tick();
    total++; if (err_pulse !== 1'b0) begin bad++; $display("FAIL reset_err_pulse: got %b want 0", err_pulse); end
    total++; if (err_chid !== 7'd0) begin bad++; $display("FAIL reset_err_chid: got %0d want 0", err_chid); end
    total++; if (cfg_dout !== 16'h0) begin bad++; $display("FAIL reset_cfg_dout: got %h want 0000", cfg_dout); end
    cfg_n_cs = 1'b1;
    cfg_n_oe = 1'b1;
    rst = 1'b0;
    idle(2);
    cfg_read(ADDR_CTRL, rd);
    total++; if (rd !== 16'h0) begin bad++; $display("FAIL reset_ctrl: got %h want 0000", rd); end
    cfg_read(ADDR_WORDS_LO, rd);
    total++; if (rd !== 16'h0) begin bad++; $display("FAIL reset_words: got %h want 0000", rd); end
  endtask

  task automatic test_in_order();
    logic [CFG_DW-1:0] rd;
    int p0;
    cfg_write(ADDR_CTRL, 16'h0001);
    cfg_write(ADDR_SEL, 16'd5);
    p0 = pulse_cnt;
    for (int i = 0; i < 4; i++) send(7'd5, 32'd10 + 32'(i));
    idle(3);
    total++; if (pulse_cnt != p0) begin bad++; $display("FAIL in_order_pulses: got %0d want 0", pulse_cnt - p0); end
    cfg_read(ADDR_ERR_CNT, rd);
    total++; if (rd !== 16'h0) begin bad++; $display("FAIL in_order_err_cnt: got %h want 0000", rd); end
    cfg_read(ADDR_LOCK, rd);
    total++; if (rd !== 16'h1) begin bad++; $display("FAIL in_order_lock: got %h want 0001", rd); end
    cfg_read(ADDR_WORDS_LO, rd);
    total++; if (rd !== 16'h4) begin bad++; $display("FAIL in_order_words: got %h want 0004", rd); end
    cfg_read(ADDR_CTRL, rd);
    total++; if (rd !== 16'h1) begin bad++; $display("FAIL ctrl_readback: got %h want 0001", rd); end
    tick();
    total++; if (cfg_dout !== 16'h0) begin bad++; $display("FAIL dout_idle: got %h want 0000", cfg_dout); end
  endtask

  task automatic test_mismatch();
    logic [CFG_DW-1:0] rd;
    int p0;
    p0 = pulse_cnt;
    send(7'd5, 32'd20);
    total++; if (err_pulse !== 1'b0) begin bad++; $display("FAIL mismatch_early: got %b want 0", err_pulse); end
    send(7'd5, 32'd21);
    total++; if (err_pulse !== 1'b1) begin bad++; $display("FAIL mismatch_pulse: got %b want 1", err_pulse); end
    total++; if (err_chid !== 7'd5) begin bad++; $display("FAIL mismatch_chid: got %0d want 5", err_chid); end
    tick();
    total++; if (err_pulse !== 1'b0) begin bad++; $display("FAIL mismatch_resync: got %b want 0", err_pulse); end
    idle(2);
    total++; if (pulse_cnt - p0 != 1) begin bad++; $display("FAIL mismatch_pulses: got %0d want 1", pulse_cnt - p0); end
    cfg_read(ADDR_ERR_CNT, rd);
    total++; if (rd !== 16'h1) begin bad++; $display("FAIL mismatch_err_cnt: got %h want 0001", rd); end
    cfg_read(ADDR_TOTAL_LO, rd);
    total++; if (rd !== 16'h1) begin bad++; $display("FAIL mismatch_total: got %h want 0001", rd); end
  endtask

  task automatic test_wrap_badchid();
    logic [CFG_DW-1:0] rd;
    int p0;
    cfg_write(ADDR_SEL, 16'd79);
    p0 = pulse_cnt;
    send(7'd79, 32'hFFFF_FFFE);
    send(7'd79, 32'hFFFF_FFFF);
    send(7'd79, 32'h0000_0000);
    send(7'd80, 32'h0000_0001);
    send(7'd127, 32'h0000_0005);
    idle(3);
    total++; if (pulse_cnt != p0) begin bad++; $display("FAIL wrap_pulses: got %0d want 0", pulse_cnt - p0); end
    cfg_read(ADDR_BADCHID, rd);
    total++; if (rd !== 16'h2) begin bad++; $display("FAIL badchid: got %h want 0002", rd); end
    cfg_read(ADDR_LOCK, rd);
    total++; if (rd !== 16'h1) begin bad++; $display("FAIL wrap_lock: got %h want 0001", rd); end
    cfg_read(ADDR_ERR_CNT, rd);
    total++; if (rd !== 16'h0) begin bad++; $display("FAIL wrap_err_cnt: got %h want 0000", rd); end
    cfg_read(ADDR_WORDS_LO, rd);
    total++; if (rd !== 16'h9) begin bad++; $display("FAIL wrap_words: got %h want 0009", rd); end
  endtask

  task automatic test_back_to_back();
    logic [CFG_DW-1:0] rd;
    logic [CHID_W-1:0] chs  [8];
    logic [SEQ_W-1:0]  seqs [8];
    int p0;
    chs  = '{7'd3, 7'd4, 7'd3, 7'd3, 7'd4, 7'd3, 7'd4, 7'd4};
    seqs = '{32'd100, 32'd200, 32'd101, 32'd102, 32'd201, 32'd103, 32'd202, 32'd203};
    p0 = pulse_cnt;
    for (int i = 0; i < 8; i++) send(chs[i], seqs[i]);
    idle(3);
    total++; if (pulse_cnt != p0) begin bad++; $display("FAIL b2b_pulses: got %0d want 0", pulse_cnt - p0); end
    cfg_write(ADDR_SEL, 16'd3);
    cfg_read(ADDR_ERR_CNT, rd);
    total++; if (rd !== 16'h0) begin bad++; $display("FAIL b2b_err_cnt3: got %h want 0000", rd); end
    cfg_read(ADDR_LOCK, rd);
    total++; if (rd !== 16'h1) begin bad++; $display("FAIL b2b_lock3: got %h want 0001", rd); end
    cfg_write(ADDR_SEL, 16'd4);
    cfg_read(ADDR_ERR_CNT, rd);
    total++; if (rd !== 16'h0) begin bad++; $display("FAIL b2b_err_cnt4: got %h want 0000", rd); end
    cfg_read(ADDR_WORDS_LO, rd);
    total++; if (rd !== 16'd17) begin bad++; $display("FAIL b2b_words: got %h want 0011", rd); end
    cfg_read(ADDR_TOTAL_LO, rd);
    total++; if (rd !== 16'h1) begin bad++; $display("FAIL b2b_total: got %h want 0001", rd); end
  endtask

  task automatic test_saturate();
    logic [CFG_DW-1:0] rd;
    int p0;
    // Clear (keeping enable) so TOTAL counts only this scenario.
    cfg_write(ADDR_CTRL, 16'h0003);
    cfg_read(ADDR_TOTAL_LO, rd);
    total++; if (rd !== 16'h0) begin bad++; $display("FAIL clear_total: got %h want 0000", rd); end
    cfg_read(ADDR_BADCHID, rd);
    total++; if (rd !== 16'h0) begin bad++; $display("FAIL clear_badchid: got %h want 0000", rd); end
    cfg_write(ADDR_SEL, 16'd5);
    cfg_read(ADDR_LOCK, rd);
    total++; if (rd !== 16'h0) begin bad++; $display("FAIL clear_lock5: got %h want 0000", rd); end
    cfg_read(ADDR_CTRL, rd);
    total++; if (rd !== 16'h1) begin bad++; $display("FAIL clear_reads_zero: got %h want 0001", rd); end
    // First seq 0 locks; each repeat of 0 is then a mismatch (expected 1).
    p0 = pulse_cnt;
    data_valid = 1'b1;
    chid_in    = 7'd7;
    data_in    = {{(DATA_W-SEQ_W){1'b1}}, 32'd0};
    for (int i = 0; i < 32'h10003; i++) tick();
    data_valid = 1'b0;
    idle(3);
    total++; if (pulse_cnt - p0 != 32'h10002) begin bad++; $display("FAIL sat_pulses: got %0d want %0d", pulse_cnt - p0, 32'h10002); end
    cfg_write(ADDR_SEL, 16'd7);
    cfg_read(ADDR_ERR_CNT, rd);
    total++; if (rd !== 16'hFFFF) begin bad++; $display("FAIL sat_err_cnt: got %h want ffff", rd); end
    cfg_read(ADDR_TOTAL_LO, rd);
    total++; if (rd !== 16'h0002) begin bad++; $display("FAIL sat_total_lo: got %h want 0002", rd); end
    cfg_read(ADDR_TOTAL_HI, rd);
    total++; if (rd !== 16'h0001) begin bad++; $display("FAIL sat_total_hi: got %h want 0001", rd); end
    cfg_read(ADDR_WORDS_LO, rd);
    total++; if (rd !== 16'h0003) begin bad++; $display("FAIL sat_words_lo: got %h want 0003", rd); end
    cfg_read(ADDR_WORDS_HI, rd);
    total++; if (rd !== 16'h0001) begin bad++; $display("FAIL sat_words_hi: got %h want 0001", rd); end
    // Out-of-range select reads zero status but keeps its value.
    cfg_write(ADDR_SEL, 16'd100);
    cfg_read(ADDR_SEL, rd);
    total++; if (rd !== 16'd100) begin bad++; $display("FAIL sel_readback: got %h want 0064", rd); end
    cfg_read(ADDR_ERR_CNT, rd);
    total++; if (rd !== 16'h0) begin bad++; $display("FAIL sel_oor_err_cnt: got %h want 0000", rd); end
    cfg_read(ADDR_LOCK, rd);
    total++; if (rd !== 16'h0) begin bad++; $display("FAIL sel_oor_lock: got %h want 0000", rd); end
  endtask

  task automatic test_clear_coincident();
    logic [CFG_DW-1:0] rd;
    cfg_write(ADDR_SEL, 16'd9);
    send(7'd9, 32'd1);
    send(7'd9, 32'd5);
    // This write lands on the same edge where S2 sees the seq 5 mismatch.
    cfg_write(ADDR_CTRL, 16'h0003);
    total++; if (err_pulse !== 1'b1) begin bad++; $display("FAIL clr_pulse: got %b want 1", err_pulse); end
    total++; if (err_chid !== 7'd9) begin bad++; $display("FAIL clr_chid: got %0d want 9", err_chid); end
    idle(2);
    cfg_read(ADDR_ERR_CNT, rd);
    total++; if (rd !== 16'h0) begin bad++; $display("FAIL clr_err_cnt9: got %h want 0000", rd); end
    cfg_read(ADDR_LOCK, rd);
    total++; if (rd !== 16'h0) begin bad++; $display("FAIL clr_lock9: got %h want 0000", rd); end
    cfg_read(ADDR_TOTAL_LO, rd);
    total++; if (rd !== 16'h0) begin bad++; $display("FAIL clr_total_lo: got %h want 0000", rd); end
    cfg_read(ADDR_TOTAL_HI, rd);
    total++; if (rd !== 16'h0) begin bad++; $display("FAIL clr_total_hi: got %h want 0000", rd); end
    cfg_read(ADDR_WORDS_LO, rd);
    total++; if (rd !== 16'h0) begin bad++; $display("FAIL clr_words_lo: got %h want 0000", rd); end
    cfg_write(ADDR_SEL, 16'd7);
    cfg_read(ADDR_ERR_CNT, rd);
    total++; if (rd !== 16'h0) begin bad++; $display("FAIL clr_err_cnt7: got %h want 0000", rd); end
  endtask

  task automatic test_reset_midstream();
    logic [CFG_DW-1:0] rd;
    int p0;
    p0 = pulse_cnt;
    send(7'd9, 32'd1);
    send(7'd9, 32'd50);
    // A mismatch is sitting in S1; reset must discard it.
    rst = 1'b1;
    #1;
    total++; if (err_pulse !== 1'b0) begin bad++; $display("FAIL rst_pulse: got %b want 0", err_pulse); end
    tick();
    rst = 1'b0;
    idle(3);
    total++; if (pulse_cnt != p0) begin bad++; $display("FAIL rst_pulses: got %0d want 0", pulse_cnt - p0); end
    cfg_read(ADDR_CTRL, rd);
    total++; if (rd !== 16'h0) begin bad++; $display("FAIL rst_ctrl: got %h want 0000", rd); end
    cfg_read(ADDR_SEL, rd);
    total++; if (rd !== 16'h0) begin bad++; $display("FAIL rst_sel: got %h want 0000", rd); end
    cfg_write(ADDR_SEL, 16'd9);
    cfg_read(ADDR_LOCK, rd);
    total++; if (rd !== 16'h0) begin bad++; $display("FAIL rst_lock9: got %h want 0000", rd); end
    cfg_read(ADDR_WORDS_LO, rd);
    total++; if (rd !== 16'h0) begin bad++; $display("FAIL rst_words: got %h want 0000", rd); end
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_mismatch();
    test_wrap_badchid();
    test_back_to_back();
    test_saturate();
    test_clear_coincident();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/odu_data_checker.md
Name: odu_data_checker

Overview:
- Consumes the generator output stream: a 7-bit channel id and a 387-bit word, one word per cycle.
- Verifies a per-channel incrementing 32-bit sequence in data_in[31:0] for 80 channels.
- Counts errors per channel and in total; flags each error on a pulse output.
- Exposes status through the same 16-bit cfg bus style as the generator's control block; sits directly downstream of odu_gen_data_top.

Parameters:
NUM_CH, 80, number of checked channels (valid chid 0..NUM_CH-1)
DATA_W, 387, input word width
SEQ_W, 32, checked sequence field width, data_in[SEQ_W-1:0]
ERR_W, 16, per-channel error counter width (saturating)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
data_valid  in  1  data_in/chid_in qualify this cycle
chid_in  in  7  channel id of word
data_in  in  DATA_W  word; only [SEQ_W-1:0] checked, rest ignored
cfg_n_cs  in  1  cfg chip select, active low
cfg_n_we  in  1  cfg write enable, active low
cfg_n_oe  in  1  cfg output enable, active low
cfg_addr  in  4  register address
cfg_din  in  16  write data
cfg_dout  out  16  read data
err_pulse  out  1  one-cycle pulse per sequence error
err_chid  out  7  channel of the error; valid with err_pulse

Behaviour:
- Reset (async, rst=1): all outputs 0; CTRL.enable=0; every lock bit, expected value, counter 0; SEL=0.
- Pipeline: S1 registers valid/chid/seq; S2 compares and updates. Word at cycle N -> err_pulse/err_chid at N+2. Full rate, no stall.
- Accept a word only if data_valid=1 and CTRL.enable=1; otherwise no state change.
- chid_in >= NUM_CH: word dropped, BADCHID increments (saturating 0xFFFF), no err_pulse.
- Unlocked channel: expected <= seq+1 (mod 2^SEQ_W), lock <= 1, no error.
- Locked channel: seq == expected -> expected <= seq+1. Mismatch -> err_pulse=1, err_chid=chid, per-channel count +1 (saturate 0xFFFF), TOTAL +1 (saturate 0xFFFFFFFF), resync expected <= seq+1, lock stays 1.
- Wrap: expected 0xFFFFFFFF followed by seq 0 is not an error.
- Same channel back-to-back: S2 must use the update from the preceding cycle (forwarding); no false errors.
- WORDS counts every accepted valid-chid word (32-bit, saturating).
- Cfg write: on clk edge with cfg_n_cs=0 and cfg_n_we=0. Cfg read: cfg_dout registered, updated on cycle after cfg_n_cs=0 and cfg_n_oe=0; otherwise 0. Unmapped addresses read 0; writes to them are ignored.
- Register map:
  0x0 CTRL: bit0 enable RW; bit1 clear W, self-clearing, reads 0.
  0x1 SEL: [6:0] channel select RW.
  0x2 ERR_CNT: error count of SEL channel, RO.
  0x3 LOCK: bit0 lock of SEL channel, RO.
  0x4/0x5 TOTAL lo/hi, RO. 0x6 BADCHID, RO. 0x7/0x8 WORDS lo/hi, RO.
- Clear: zeroes all counters, lock bits, expected values in one cycle. Clear coincident with an S2 error: clear wins for counters/lock; err_pulse still asserts. SEL >= NUM_CH reads ERR_CNT=0, LOCK=0.
- rst mid-stream: pipeline contents discarded, no err_pulse after release until new words arrive.

Decomposition:
- Package odu_chk_pkg: NUM_CH, DATA_W, SEQ_W, ERR_W, register address constants (ADDR_CTRL..ADDR_WORDS_HI), CTRL bit indices.
- Sub-module odu_chk_cfg_regs: cfg bus decode, CTRL/SEL registers, clear pulse, registered read mux. Check pipeline and per-channel tables in the top.

Test Plan:
- Enable, chid 5 sends seq 10,11,12,13 back-to-back -> no err_pulse; ERR_CNT(SEL=5)=0, LOCK=1, WORDS=4.
- Chid 5 locked at expected 14, send 20 then 21 -> one err_pulse, err_chid=5, 2 cycles after seq 20; ERR_CNT=1, TOTAL=1.
- Chid 79 seq 0xFFFFFFFE, 0xFFFFFFFF, 0x0 -> no error; chid 80 and 127 words -> BADCHID=2, no err_pulse.
- Interleave chid 3 and 4 at full rate, chid 3 repeated back-to-back, all correct -> zero errors (forwarding check).
- 0x10002 mismatches on chid 7 -> ERR_CNT saturates at 0xFFFF; TOTAL=0x10002 (lo 0x0002, hi 0x0001).
- CTRL.clear written same cycle as an S2 error -> err_pulse=1, all counters and locks read 0 afterwards; rst asserted mid-stream -> all cfg reads 0, no pulse.
